mem_arbiter: RTL

//  Shares one burst-memory channel between I-cache and D-cache line ports; sits upstream of the deserializer.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_grant.sv | 56 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D-cache memory arbiter.
// Imported by mem_arb_grant and mem_arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_BURST = 3'd3,
      WR_WAIT  = 3'd4,
      RESP     = 3'd5
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_t;

   // Byte offset bits inside one cache line.
   localparam int LINE_OFS = 5;

   function automatic req_t other_req(input req_t r);
      return (r == REQ_D) ? REQ_I : REQ_D;
   endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks one of two cache requesters and latches the winner.
// With MEM_ARB_RR_EN the last granted requester loses a tie.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic sample,
`ifdef MEM_ARB_RR_EN
   input  logic upd,
`endif
   output logic any_req,
   output req_t win,
   output req_t gnt_id
);

   req_t tie_win;

`ifdef MEM_ARB_RR_EN
   req_t ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= REQ_I;
      end else if (upd) begin
         ptr <= gnt_id;
      end
   end

   assign tie_win = other_req(ptr);
`else
   assign tie_win = REQ_D;
`endif

   always_comb begin
      any_req = i_req | d_req;
      win     = REQ_D;
      unique case (1'b1)
         d_req & ~i_req: win = REQ_D;
         i_req & ~d_req: win = REQ_I;
         i_req & d_req:  win = tie_win;
         default:        win = REQ_D;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_id <= REQ_I;
      end else if (sample) begin
         gnt_id <= win;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst-memory channel between I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-break (default: D-cache wins).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] icache_addr,
   input  logic              icache_read,
   output logic [LINE_W-1:0] icache_rdata,
   output logic              icache_resp,
   input  logic [ADDR_W-1:0] dcache_addr,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              dcache_resp,
   input  logic              bmem_ready,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic              ser_write,
   output logic [LINE_W-1:0] ser_wdata,
   input  logic [LINE_W-1:0] ser_rdata,
   input  logic              ser_resp
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~ADDR_W'((1 << LINE_OFS) - 1);

   state_t            state;
   logic [CNT_W-1:0]  beat_cnt;
   logic              any_req;
   logic              sample;
   req_t              win;
   req_t              gnt_id;
   logic [ADDR_W-1:0] win_addr;
   logic              win_wr;

   assign sample   = (state == IDLE) && any_req;
   assign win_addr = (win == REQ_D) ? dcache_addr : icache_addr;
   assign win_wr   = (win == REQ_D) && dcache_write;

   // Writeback data is only presented while a write burst is live.
   assign ser_wdata = ser_write ? dcache_wdata : '0;

   mem_arb_grant u_grant (
      .clk     (clk),
      .rst     (rst),
      .i_req   (icache_read),
      .d_req   (dcache_read | dcache_write),
      .sample  (sample),
`ifdef MEM_ARB_RR_EN
      .upd     (state == RESP),
`endif
      .any_req (any_req),
      .win     (win),
      .gnt_id  (gnt_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         bmem_addr    <= '0;
         bmem_read    <= 1'b0;
         bmem_write   <= 1'b0;
         ser_write    <= 1'b0;
         icache_resp  <= 1'b0;
         dcache_resp  <= 1'b0;
         icache_rdata <= '0;
         dcache_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  bmem_addr <= win_addr & ALIGN_MASK;
                  if (win_wr) begin
                     state      <= WR_BURST;
                     bmem_write <= 1'b1;
                     ser_write  <= 1'b1;
                     beat_cnt   <= '0;
                  end else begin
                     state     <= RD_ISSUE;
                     bmem_read <= 1'b1;
                  end
               end
            end
            RD_ISSUE: begin
               if (bmem_ready) begin
                  bmem_read <= 1'b0;
                  state     <= RD_WAIT;
               end
            end
            WR_BURST: begin
               if (bmem_ready) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt   <= '0;
                     bmem_write <= 1'b0;
                     ser_write  <= 1'b0;
                     state      <= WR_WAIT;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               if (ser_resp) begin
                  if (gnt_id == REQ_D) begin
                     dcache_rdata <= ser_rdata;
                  end else begin
                     icache_rdata <= ser_rdata;
                  end
                  dcache_resp <= (gnt_id == REQ_D);
                  icache_resp <= (gnt_id == REQ_I);
                  state       <= RESP;
               end
            end
            WR_WAIT: begin
               if (ser_resp) begin
                  dcache_resp <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               icache_resp <= 1'b0;
               dcache_resp <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
